mode_arbiter: RTL and testbench

Sequencer for the digital clock's shared resources: the LCD character path and the four debounced push-buttons. It decodes `dip_sw` into an active mode (watch, watch-set, stopwatch, alarm) and only switches modes after a stability filter and at an LCD frame boundary. It gives button presses, as one-cycle pulses, only to the active mode, and optionally pre-empts the display when an alarm fires. It sits between the mode blocks and `lcd_driver` in `digital_clock`, replacing the combinational dip-switch mux.

---
 rtl/mode_arbiter.sv | 128 ++++++++++++
 tb/tb_mode_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mode_arbiter.sv
// mode_arbiter: debounced, frame-aligned mode switching, button routing and LCD character mux
// Ports: clk, rst (async active-low), en_1hz strobe, dip_sw mode request, sw_in button levels,
//   index_char LCD index, data_mode0..3 per-mode characters, alarm_req alarm level;
//   data_char registered LCD character, data_sw0..3 per-mode press pulses, mode, alarm_active.
// Optional macro MODE_ARB_ALARM_PREEMPT_EN adds alarm pre-emption of the display.
module mode_arbiter #(
  parameter int DEB_CYCLES = 16,
  parameter int ALARM_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_1hz,
  input  logic [3:0] dip_sw,
  input  logic [3:0] sw_in,
  input  logic [4:0] index_char,
  input  logic [7:0] data_mode0,
  input  logic [7:0] data_mode1,
  input  logic [7:0] data_mode2,
  input  logic [7:0] data_mode3,
  input  logic       alarm_req,
  output logic [7:0] data_char,
  output logic [3:0] data_sw0,
  output logic [3:0] data_sw1,
  output logic [3:0] data_sw2,
  output logic [3:0] data_sw3,
  output logic [1:0] mode,
  output logic       alarm_active
);
  localparam logic [1:0] RUN = 2'd0, SETTLE = 2'd1, WAIT_FRAME = 2'd2, ALARM = 2'd3;
  localparam logic [15:0] DEB_MAX = 16'(DEB_CYCLES - 1);
  logic [1:0] state, cand, dec;
  logic [15:0] cnt;
  logic [3:0] sw_prev, sw_edge;
  logic [4:0] idx_prev;
  logic [7:0] disp;
  logic frame, route, alarm_edge, alarm_exit;
  assign dec = dip_sw == 4'b0001 ? 2'd1 : dip_sw == 4'b0010 ? 2'd2 : dip_sw == 4'b0100 ? 2'd3 : 2'd0;
  assign sw_edge = sw_in & ~sw_prev;
  assign frame = idx_prev == 5'd31 && index_char == 5'd0;
  // presses are swallowed while the alarm owns the display, including the entry cycle
  assign route = state != ALARM && !alarm_edge;
  assign disp = state == ALARM ? data_mode3 :
                mode == 2'd0 ? data_mode0 :
                mode == 2'd1 ? data_mode1 :
                mode == 2'd2 ? data_mode2 : data_mode3;
`ifdef MODE_ARB_ALARM_PREEMPT_EN
  logic alarm_prev;
  logic [7:0] sec;
  assign alarm_edge = alarm_req & ~alarm_prev;
  assign alarm_exit = state == ALARM && (sec == 8'd0 || |sw_edge);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      alarm_prev <= 1'b0;
      sec <= 8'd0;
      alarm_active <= 1'b0;
    end else begin
      alarm_prev <= alarm_req;
      if (alarm_edge) begin
        sec <= 8'(ALARM_SEC);
        alarm_active <= 1'b1;
      end else if (alarm_exit) alarm_active <= 1'b0;
      else if (state == ALARM && en_1hz) sec <= sec - 8'd1;
    end
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_req, en_1hz};
  assign alarm_edge = 1'b0;
  assign alarm_exit = 1'b0;
  assign alarm_active = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      mode <= 2'd0;
      cand <= 2'd0;
      cnt <= 16'd0;
      sw_prev <= 4'd0;
      idx_prev <= 5'd0;
      data_char <= 8'h20;
      data_sw0 <= 4'd0;
      data_sw1 <= 4'd0;
      data_sw2 <= 4'd0;
      data_sw3 <= 4'd0;
    end else begin
      sw_prev <= sw_in;
      idx_prev <= index_char;
      data_char <= disp;
      data_sw0 <= route && mode == 2'd0 ? sw_edge : 4'd0;
      data_sw1 <= route && mode == 2'd1 ? sw_edge : 4'd0;
      data_sw2 <= route && mode == 2'd2 ? sw_edge : 4'd0;
      data_sw3 <= route && mode == 2'd3 ? sw_edge : 4'd0;
      if (alarm_edge) begin
        state <= ALARM;
        mode <= 2'd3;
      end else
        case (state)
          RUN:
            if (dec != mode) begin
              cand <= dec;
              cnt <= 16'd0;
              state <= SETTLE;
            end
          SETTLE:
            if (dec == mode) state <= RUN;
            else if (dec != cand) begin
              cand <= dec;
              cnt <= 16'd0;
            end else if (cnt == DEB_MAX) state <= WAIT_FRAME;
            else cnt <= cnt + 16'd1;
          WAIT_FRAME:
            if (dec == mode) state <= RUN;
            else if (dec != cand) begin
              cand <= dec;
              cnt <= 16'd0;
              state <= SETTLE;
            end else if (frame) begin
              mode <= cand;
              state <= RUN;
            end
          default:
            // dip switches were static during the alarm, so skip the stability filter
            if (alarm_exit) begin
              cand <= dec;
              state <= dec == 2'd3 ? RUN : WAIT_FRAME;
            end
        endcase
    end
endmodule

// File: tb/tb_mode_arbiter.sv
module tb_mode_arbiter;
  logic clk = 0, rst = 1, en_1hz = 0, alarm_req = 0;
  logic [3:0] dip_sw = 0, sw_in = 0;
  logic [4:0] index_char = 0;
  logic [7:0] data_mode0 = 8'h30, data_mode1 = 8'h31, data_mode2 = 8'h32, data_mode3 = 8'h33;
  logic [7:0] data_char;
  logic [3:0] data_sw0, data_sw1, data_sw2, data_sw3;
  logic [1:0] mode;
  logic alarm_active;
  int checks = 0, errors = 0;

  typedef struct {logic kind; logic [15:0] val; string name;} ev_t;
  ev_t q[$];

  mode_arbiter dut (
    .clk(clk), .rst(rst), .en_1hz(en_1hz), .dip_sw(dip_sw), .sw_in(sw_in),
    .index_char(index_char), .data_mode0(data_mode0), .data_mode1(data_mode1),
    .data_mode2(data_mode2), .data_mode3(data_mode3), .alarm_req(alarm_req),
    .data_char(data_char), .data_sw0(data_sw0), .data_sw1(data_sw1),
    .data_sw2(data_sw2), .data_sw3(data_sw3), .mode(mode), .alarm_active(alarm_active)
  );

  always #5 clk = ~clk;

  task automatic push(input logic kind, input logic [15:0] val, input string name);
    ev_t e;
    e.kind = kind;
    e.val = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic sb_check(input logic kind, input logic [15:0] val);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d got %h, none expected at %0t", kind, val, $time);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL %s got kind=%0d val=%h, expected kind=%0d val=%h", e.name, kind, val, e.kind, e.val);
      end
    end
  endtask

  // monitor: SW events are {data_sw3,data_sw2,data_sw1,data_sw0}; MODE events are {alarm_active,mode}
  logic [2:0] last_am = 3'd0;
  always @(negedge clk) begin
    logic [15:0] sw;
    logic [2:0] am;
    sw = {data_sw3, data_sw2, data_sw1, data_sw0};
    am = {alarm_active, mode};
    if (sw != 16'd0) sb_check(1'b0, sw);
    if (am != last_am) begin
      sb_check(1'b1, {13'd0, am});
      last_am = am;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wrap();
    index_char = 5'd31;
    tick();
    index_char = 5'd0;
    tick();
  endtask

  initial begin
    #1 rst = 0;
    #2;
    chk("reset_data_char", {8'd0, data_char}, 16'h0020);
    chk("reset_mode", {14'd0, mode}, 16'd0);
    chk("reset_alarm", {15'd0, alarm_active}, 16'd0);
    chk("reset_data_sw", {data_sw3, data_sw2, data_sw1, data_sw0}, 16'd0);
    tick(2);
    rst = 1;
    tick();
    chk("char_mode0", {8'd0, data_char}, 16'h0030);
    data_mode0 = 8'h55;
    chk("char_latency_hold", {8'd0, data_char}, 16'h0030);
    tick();
    chk("char_latency_update", {8'd0, data_char}, 16'h0055);
    sw_in = 4'b0100;
    push(1'b0, 16'h0004, "sw2_mode0");
    tick();
    sw_in = 4'b0000;
    tick(2);
    dip_sw = 4'b0010;
    tick(5);
    dip_sw = 4'b0000;
    tick(3);
    wrap();
    chk("glitch_mode", {14'd0, mode}, 16'd0);
    dip_sw = 4'b0010;
    tick(10);
    wrap();
    chk("early_wrap_mode", {14'd0, mode}, 16'd0);
    tick(8);
    chk("pre_wrap_mode", {14'd0, mode}, 16'd0);
    push(1'b1, 16'h0002, "mode_to_2");
    wrap();
    chk("mode2", {14'd0, mode}, 16'd2);
    tick();
    chk("char_mode2", {8'd0, data_char}, 16'h0032);
    sw_in = 4'b0001;
    push(1'b0, 16'h0100, "sw0_mode2");
    tick();
    sw_in = 4'b0000;
    tick(2);
    dip_sw = 4'b0001;
    tick(20);
    push(1'b1, 16'h0001, "mode_to_1");
    wrap();
    chk("mode1", {14'd0, mode}, 16'd1);
`ifdef MODE_ARB_ALARM_PREEMPT_EN
    alarm_req = 1;
    sw_in = 4'b0010;
    push(1'b1, 16'h0007, "alarm_entry");
    tick();
    chk("alarm_active_entry", {15'd0, alarm_active}, 16'd1);
    chk("alarm_mode_entry", {14'd0, mode}, 16'd3);
    alarm_req = 0;
    sw_in = 4'b0000;
    tick();
    chk("alarm_char", {8'd0, data_char}, 16'h0033);
    push(1'b1, 16'h0003, "alarm_timeout");
    for (int i = 0; i < 29; i++) begin
      en_1hz = 1;
      tick();
      en_1hz = 0;
      tick();
    end
    chk("alarm_after_29", {15'd0, alarm_active}, 16'd1);
    en_1hz = 1;
    tick();
    en_1hz = 0;
    tick();
    chk("alarm_after_30", {15'd0, alarm_active}, 16'd0);
    push(1'b1, 16'h0001, "alarm_back_to_1");
    wrap();
    chk("alarm_mode_restored", {14'd0, mode}, 16'd1);
    alarm_req = 1;
    push(1'b1, 16'h0007, "alarm_entry2");
    tick();
    alarm_req = 0;
    tick();
    sw_in = 4'b0001;
    push(1'b1, 16'h0003, "alarm_button_exit");
    tick();
    chk("alarm_button_exit", {15'd0, alarm_active}, 16'd0);
    sw_in = 4'b0000;
    tick();
    push(1'b1, 16'h0001, "alarm2_back_to_1");
    wrap();
    chk("alarm2_mode_restored", {14'd0, mode}, 16'd1);
`else
    alarm_req = 1;
    tick(3);
    alarm_req = 0;
    chk("alarm_ignored_active", {15'd0, alarm_active}, 16'd0);
    chk("alarm_ignored_mode", {14'd0, mode}, 16'd1);
`endif
    dip_sw = 4'b0010;
    tick(20);
    push(1'b1, 16'h0000, "async_reset_mode");
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("async_reset_char", {8'd0, data_char}, 16'h0020);
    chk("async_reset_mode", {14'd0, mode}, 16'd0);
    chk("async_reset_alarm", {15'd0, alarm_active}, 16'd0);
    chk("async_reset_sw", {data_sw3, data_sw2, data_sw1, data_sw0}, 16'd0);
    tick(2);
    rst = 1;
    dip_sw = 4'b0000;
    tick(2);
    chk("post_reset_char", {8'd0, data_char}, 16'h0055);
    tick(2);
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing, expected val=%h", e.name, e.val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
